// File: rtl/hsid_pkg.sv
// Shared state type and width helpers for the HSID squared-difference accumulator.
package hsid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hsid_acc_state_t;

  function automatic int hsid_band_width(input int max_bands);
    return $clog2(max_bands) + 32'sd1;
  endfunction

  // Worst case is MAX_BANDS full-scale squares, so this width can never wrap.
  function automatic int hsid_acc_width(input int data_width, input int max_bands);
    return (32'sd2 * data_width) + $clog2(max_bands);
  endfunction

endpackage

// File: rtl/hsid_sq_df_acc_abv.sv
// Protocol properties for hsid_sq_df_acc: paired pops only from non-empty FIFOs,
// single-cycle result strobe, and clear always returns the block to idle.
module hsid_sq_df_acc_abv (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic a_empty,
  input logic b_empty,
  input logic a_rd_en,
  input logic b_rd_en,
  input logic acc_valid,
  input logic busy
);

  ap_pop_when_ready: assert property (@(posedge clk) disable iff (rst)
    a_rd_en |-> (!a_empty && !b_empty))
    else $error("pop issued while a FIFO is empty");

  ap_pop_paired: assert property (@(posedge clk) disable iff (rst)
    a_rd_en == b_rd_en)
    else $error("a_rd_en and b_rd_en differ");

  ap_valid_pulse: assert property (@(posedge clk) disable iff (rst)
    acc_valid |=> !acc_valid)
    else $error("acc_valid held longer than one cycle");

  ap_clear_idle: assert property (@(posedge clk) disable iff (rst)
    clear |=> !busy)
    else $error("busy still high after clear");

endmodule

// File: rtl/hsid_sq_df_stage.sv
// Two-stage registered |a-b| squarer; a valid bit rides alongside each stage.
module hsid_sq_df_stage #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  output logic                        out_valid,
  output logic [2*DATA_WIDTH-1:0]     sq
);

  logic signed [DATA_WIDTH:0]   diff_r;
  logic                         diff_v_r;
  logic [DATA_WIDTH-1:0]        mag_s;
  logic [2*DATA_WIDTH-1:0]      sq_r;
  logic                         sq_v_r;

  // Magnitude of the signed difference; |a-b| always fits DATA_WIDTH bits.
  always_comb begin
    mag_s = diff_r[DATA_WIDTH-1:0];
    if (diff_r[DATA_WIDTH]) begin
      mag_s = ~diff_r[DATA_WIDTH-1:0] + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_s = diff_r[DATA_WIDTH-1:0];
    end
  end

  // Difference stage then square stage; clear only flushes the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_r   <= '0;
      diff_v_r <= 1'b0;
      sq_r     <= '0;
      sq_v_r   <= 1'b0;
    end else if (clear) begin
      diff_v_r <= 1'b0;
      sq_v_r   <= 1'b0;
    end else begin
      diff_v_r <= in_valid;
      sq_v_r   <= diff_v_r;
      if (in_valid) begin
        diff_r <= $signed({1'b0, a}) - $signed({1'b0, b});
      end
      if (diff_v_r) begin
        sq_r <= {{DATA_WIDTH{1'b0}}, mag_s} * {{DATA_WIDTH{1'b0}}, mag_s};
      end
    end
  end

  assign out_valid = sq_v_r;
  assign sq        = sq_r;

endmodule

// File: rtl/hsid_sq_df_acc.sv
// Squared-difference distance accumulator: pops paired bands from the pixel and
// reference FIFOs and emits sum((a-b)^2) once per vector.
module hsid_sq_df_acc
  import hsid_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  MAX_BANDS  = 128,
  localparam int BAND_WIDTH = hsid_band_width(MAX_BANDS),
  localparam int ACC_WIDTH  = hsid_acc_width(DATA_WIDTH, MAX_BANDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [BAND_WIDTH-1:0]   num_bands,
  input  logic                    a_empty,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_rd_en,
  input  logic                    b_empty,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic                    b_rd_en,
  output logic                    b_loop_en,
  output logic                    busy,
  output logic [ACC_WIDTH-1:0]    acc_data,
  output logic                    acc_valid
);

  localparam int SQ_WIDTH = 32'sd2 * DATA_WIDTH;

  hsid_acc_state_t          state_r;
  logic [BAND_WIDTH-1:0]    num_r;
  logic [BAND_WIDTH-1:0]    issued_r;
  logic [BAND_WIDTH-1:0]    num_clamp_s;
  logic                     rd_en_s;
  logic                     rd_d1_r;
  logic                     sq_v_s;
  logic [SQ_WIDTH-1:0]      sq_s;
  logic [ACC_WIDTH-1:0]     acc_r;
  logic [ACC_WIDTH-1:0]     acc_sum_s;
  logic [ACC_WIDTH-1:0]     acc_data_r;
  logic                     acc_valid_r;
  logic                     busy_r;
  logic                     loop_r;

  // Oversized band counts saturate at MAX_BANDS.
  always_comb begin
    if (num_bands > BAND_WIDTH'(MAX_BANDS)) begin
      num_clamp_s = BAND_WIDTH'(MAX_BANDS);
    end else begin
      num_clamp_s = num_bands;
    end
  end

  // Pop both FIFOs together, only while each has data and bands remain.
  always_comb begin
    if ((state_r == RUN) && !a_empty && !b_empty && (issued_r < num_r)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Running sum including whatever square leaves the pipeline this cycle.
  always_comb begin
    if (sq_v_s) begin
      acc_sum_s = acc_r + {{(ACC_WIDTH-SQ_WIDTH){1'b0}}, sq_s};
    end else begin
      acc_sum_s = acc_r;
    end
  end

  hsid_sq_df_stage #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (rd_d1_r),
    .a         (a_data),
    .b         (b_data),
    .out_valid (sq_v_s),
    .sq        (sq_s)
  );

  // Control FSM, band counter, accumulator and registered outputs.
  // DRAIN lasts until no FIFO read is outstanding; the final square lands
  // during DONE, so the result is committed on the DONE -> IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      num_r       <= '0;
      issued_r    <= '0;
      rd_d1_r     <= 1'b0;
      acc_r       <= '0;
      acc_data_r  <= '0;
      acc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      loop_r      <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      issued_r    <= '0;
      rd_d1_r     <= 1'b0;
      acc_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      loop_r      <= 1'b0;
    end else begin
      rd_d1_r     <= rd_en_s;
      acc_valid_r <= 1'b0;
      if (sq_v_s) begin
        acc_r <= acc_sum_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            num_r    <= num_clamp_s;
            issued_r <= '0;
            acc_r    <= '0;
            busy_r   <= 1'b1;
            if (num_clamp_s == '0) begin
              state_r <= DONE;
            end else begin
              state_r <= RUN;
              loop_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (rd_en_s) begin
            issued_r <= issued_r + {{(BAND_WIDTH-1){1'b0}}, 1'b1};
          end
          if (issued_r == num_r) begin
            state_r <= DRAIN;
            loop_r  <= 1'b0;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (!rd_d1_r) begin
            state_r <= DONE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DONE: begin
          acc_data_r  <= acc_sum_s;
          acc_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          loop_r  <= 1'b0;
        end
      endcase
    end
  end

  assign a_rd_en   = rd_en_s;
  assign b_rd_en   = rd_en_s;
  assign b_loop_en = loop_r;
  assign busy      = busy_r;
  assign acc_data  = acc_data_r;
  assign acc_valid = acc_valid_r;

endmodule
